pc_gen: RTL
===========

# pc_gen

Parametrised program-counter generator for the fetch stage. It holds the current fetch PC and advances it under a valid/ready handshake with instruction fetch. It applies redirects from trap and branch-resolution logic with fixed priority, and predicts return targets from a configurable-depth circular return-address stack (RAS). A registered debug copy of the last accepted fetch PC is provided for trace.

## Interface
Parameters:
- WIDTH, 32, address width in bits
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset (WIDTH bits)
- RAS_DEPTH, 4, return-address stack entries; power of two, ≥2

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- pc_ready  in  1  fetch accepts current pc this cycle
- trap_valid  in  1  redirect to trap_target (highest priority)
- trap_target  in  WIDTH  trap handler address
- branch_valid  in  1  redirect from execute (taken branch / mispredict)
- branch_target  in  WIDTH  resolved branch/jump target
- ras_push  in  1  push ras_push_addr (decode saw a call)
- ras_push_addr  in  WIDTH  return address to push
- ras_pop  in  1  current fetch is a predicted return; use RAS top as next pc
- pc  out  WIDTH  current fetch PC
- pc_valid  out  1  pc is valid for fetch
- prev_pc  out  WIDTH  pc of last accepted fetch (debug)
- ras_count  out  $clog2(RAS_DEPTH)+1  live RAS entries
- ras_empty  out  1  ras_count == 0

## Operation
- Reset (rst=1 at posedge): pc=RESET_VECTOR, pc_valid=0, prev_pc=RESET_VECTOR, RAS pointer=0, ras_count=0. RAS entry contents are don't-care.
- Startup: on the first edge with rst=0 and no redirect, pc_valid becomes 1 and pc holds RESET_VECTOR.
- Fetch accept: accept = pc_valid & pc_ready.
- Next-pc selection, in priority order:
  1. trap_valid: pc ← trap_target
  2. branch_valid: pc ← branch_target
  3. accept & ras_pop & !ras_empty: pc ← RAS top; the entry is consumed
  4. accept: pc ← pc + 4 (modulo 2^WIDTH, wraps silently)
  5. otherwise: hold
- Redirects (1, 2) apply regardless of pc_ready. Each sets pc_valid=1.
- ras_pop while empty: ignored; falls through to the sequential rule (4). ras_count stays 0.
- ras_pop is ignored entirely when not accepted or when a redirect wins. The RAS is unchanged in that case.
- prev_pc ← pc on every accept, including the accepted fetch in a redirect cycle; otherwise it holds.
- RAS is a circular buffer. The top pointer increments on push and decrements on consumed pop, modulo RAS_DEPTH.
  - Push when full: overwrites the oldest entry; ras_count saturates at RAS_DEPTH.
  - ras_push is honoured in every non-reset cycle, including redirect cycles.
  - Push and consumed pop in the same cycle: next pc = old top, the top entry is overwritten with ras_push_addr, and pointer and ras_count are unchanged.
- rst asserted mid-operation overrides everything. Any pending push or pop that cycle is discarded.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Redirect latency: target appears on pc one cycle after trap_valid/branch_valid is sampled.
- Sequential/RAS latency: new pc appears one cycle after the accept edge. Sustained throughput is one pc per cycle while pc_ready=1.
- ras_count and ras_empty reflect pushes and pops of the previous edge.
- pc_valid stays 0 only in the reset cycle(s) and the cycle after; it is never deasserted afterwards except by rst.

## Test plan
- Reset/start: RESET_VECTOR=32'h100; hold rst 2 cycles, then release with pc_ready=1 → pc_valid=0 during reset and the first cycle after; pc=100, 104, 108 on subsequent cycles; prev_pc trails by one accept.
- Stall and redirect priority: pc=200 with pc_ready=0 for 3 cycles → pc holds 200. Then assert trap_valid (target 0x80) and branch_valid (target 0x400) together → pc=0x80; prev_pc unchanged.
- RAS LIFO: push 0x10, 0x20, 0x30; then three accepted ras_pop cycles → pc sequence 0x30, 0x20, 0x10, ras_count goes 3→0 and ras_empty=1. A fourth pop → pc = previous pc + 4.
- RAS overflow (RAS_DEPTH=4): push 0x1..0x5 → ras_count=4; pops return 5, 4, 3, 2; then ras_empty=1.
- Push and pop in the same cycle with top=0x40 and push 0x50 → pc=0x40; ras_count unchanged; next pop returns 0x50.
- Wrap and mid-run reset: pc=32'hFFFF_FFFC with accept → pc=0. Then assert rst together with ras_push → pc=RESET_VECTOR, pc_valid=0, ras_count=0.

Source files
------------

// File: rtl/pc_gen.sv
// ---------------------------------------------------------------------------
// pc_gen : fetch-stage program-counter generator
//
// Holds the current fetch PC and advances it under a valid/ready handshake.
// Trap and branch redirects take priority, followed by RAS-predicted returns
// and then sequential pc+4. A circular return-address stack supplies return
// targets. All outputs are registered.
//
// Ports
//   clk              clock, all state updates on posedge
//   rst              synchronous active-high reset
//   pc_ready_i       fetch accepts the current pc this cycle
//   trap_valid_i     redirect to trap_target_i (highest priority)
//   trap_target_i    trap handler address
//   branch_valid_i   redirect to branch_target_i
//   branch_target_i  resolved branch/jump target
//   ras_push_i       push ras_push_addr_i onto the RAS
//   ras_push_addr_i  return address to push
//   ras_pop_i        current fetch is a predicted return
//   pc_o             current fetch PC
//   pc_valid_o       pc_o is valid for fetch
//   prev_pc_o        pc of the last accepted fetch
//   ras_count_o      live RAS entries
//   ras_empty_o      RAS holds no entries
// ---------------------------------------------------------------------------
module pc_gen #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int               RAS_DEPTH    = 4,
    localparam int              PTR_W        = $clog2(RAS_DEPTH),
    localparam int              CNT_W        = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pc_ready_i,
    input  logic             trap_valid_i,
    input  logic [WIDTH-1:0] trap_target_i,
    input  logic             branch_valid_i,
    input  logic [WIDTH-1:0] branch_target_i,
    input  logic             ras_push_i,
    input  logic [WIDTH-1:0] ras_push_addr_i,
    input  logic             ras_pop_i,
    output logic [WIDTH-1:0] pc_o,
    output logic             pc_valid_o,
    output logic [WIDTH-1:0] prev_pc_o,
    output logic [CNT_W-1:0] ras_count_o,
    output logic             ras_empty_o
);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic             pc_valid_q;
    logic [WIDTH-1:0] prev_pc_q;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             empty_q;
    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];

    logic             accept;
    logic             redirect;
    logic             pop_ok;
    logic [PTR_W-1:0] top_idx;
    logic             wr_en;
    logic [PTR_W-1:0] wr_idx;

    always_comb begin
        accept   = pc_valid_q & pc_ready_i;
        redirect = trap_valid_i | branch_valid_i;
        pop_ok   = accept & ras_pop_i & (cnt_q != '0) & ~redirect;
        // ptr_q points at the next free slot; the top entry sits just below it.
        top_idx  = ptr_q - PTR_W'(1);

        if (trap_valid_i)        pc_d = trap_target_i;
        else if (branch_valid_i) pc_d = branch_target_i;
        else if (pop_ok)         pc_d = ras_mem[top_idx];
        else if (accept)         pc_d = pc_q + WIDTH'(4);
        else                     pc_d = pc_q;

        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        wr_en  = 1'b0;
        wr_idx = ptr_q;
        if (ras_push_i && pop_ok) begin
            // Consume and refill the top slot: depth unchanged.
            wr_en  = 1'b1;
            wr_idx = top_idx;
        end else if (ras_push_i) begin
            // When full, ptr_q already points at the oldest entry.
            wr_en = 1'b1;
            ptr_d = ptr_q + PTR_W'(1);
            if (cnt_q != CNT_W'(RAS_DEPTH)) cnt_d = cnt_q + CNT_W'(1);
        end else if (pop_ok) begin
            ptr_d = top_idx;
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_VECTOR;
            pc_valid_q <= 1'b0;
            prev_pc_q  <= RESET_VECTOR;
            ptr_q      <= '0;
            cnt_q      <= '0;
            empty_q    <= 1'b1;
        end else begin
            pc_q       <= pc_d;
            pc_valid_q <= 1'b1;
            if (accept) prev_pc_q <= pc_q;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            empty_q    <= (cnt_d == '0);
        end
    end

    // Entry storage needs no reset; contents are only read when cnt_q != 0.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) ras_mem[wr_idx] <= ras_push_addr_i;
    end

    assign pc_o        = pc_q;
    assign pc_valid_o  = pc_valid_q;
    assign prev_pc_o   = prev_pc_q;
    assign ras_count_o = cnt_q;
    assign ras_empty_o = empty_q;

endmodule
